// File: rtl/fir_pkg.sv
// fir_pkg: shared widths, state encoding and coefficient sets for fir_stereo
package fir_pkg;
  localparam int NTAPS_DEF = 8;
  localparam int DW = 24;
  localparam int CW = 18;
  localparam int ACCW = DW + CW + $clog2(NTAPS_DEF);
  typedef enum logic [1:0] {IDLE, MAC_L, MAC_R, OUT} state_t;
  typedef logic signed [CW-1:0] coef_t;
  localparam coef_t COEFS [4][NTAPS_DEF] = '{
    '{18'sd65536, 18'sd0, 18'sd0, 18'sd0, 18'sd0, 18'sd0, 18'sd0, 18'sd0},
    '{18'sd8192, 18'sd8192, 18'sd8192, 18'sd8192, 18'sd8192, 18'sd8192, 18'sd8192, 18'sd8192},
    '{18'sd4096, 18'sd8192, 18'sd12288, 18'sd16384, 18'sd16384, 18'sd12288, 18'sd8192, 18'sd4096},
    '{18'sd32768, -18'sd32768, 18'sd0, 18'sd0, 18'sd0, 18'sd0, 18'sd0, 18'sd0}
  };
  // taps past the listed table are zero, so longer filters simply see silence there
  function automatic coef_t coef_at(input logic [1:0] sel, input int k);
    return (k < NTAPS_DEF) ? COEFS[sel][k[2:0]] : '0;
  endfunction
endpackage

// File: rtl/fir_mac.sv
// fir_mac: signed multiply-accumulate with clear and Q2.16 round/saturate output
module fir_mac import fir_pkg::*; #(
  parameter int AW = ACCW
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_clr,
  input  logic                 i_en,
  input  logic signed [DW-1:0] i_x,
  input  logic signed [CW-1:0] i_c,
  output logic signed [DW-1:0] o_rnd
);
  localparam logic signed [AW-1:0] MAXV = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [AW-1:0] MINV = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};
  logic signed [DW+CW-1:0] w_prod;
  logic signed [AW-1:0] r_acc, w_sum, w_rs;
  assign w_prod = i_x * i_c;
  assign w_sum = r_acc + AW'(w_prod);
  assign w_rs = (w_sum + AW'(32768)) >>> 16;
  assign o_rnd = (w_rs > MAXV) ? MAXV[DW-1:0] : (w_rs < MINV) ? MINV[DW-1:0] : w_rs[DW-1:0];
  // accumulator; clear wins so the last product of a channel is consumed via o_rnd only
  always_ff @(posedge clk) begin
    if (reset || i_clr) r_acc <= '0;
    else if (i_en) r_acc <= w_sum;
  end
endmodule

// File: rtl/fir_stereo.sv
// fir_stereo: time-multiplexed stereo FIR sharing one MAC across both channels
module fir_stereo import fir_pkg::*; #(
  parameter int NTAPS = NTAPS_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [DW-1:0] left_in,
  input  logic [DW-1:0] right_in,
  input  logic [1:0]    coef_sel,
  output logic [DW-1:0] left_out,
  output logic [DW-1:0] right_out,
  output logic          out_valid,
  output logic          busy,
  output logic          overrun
);
  localparam int KW = $clog2(NTAPS);
  localparam int AW = DW + CW + KW;
  state_t r_state, w_next;
  logic [KW-1:0] r_wr, r_k, w_idx;
  logic [1:0] r_sel;
  logic [DW-1:0] r_lbuf [NTAPS];
  logic [DW-1:0] r_rbuf [NTAPS];
  logic [DW-1:0] r_hold_l;
  logic signed [DW-1:0] w_x, w_rnd;
  logic w_last, w_accept;
  assign w_last = r_k == KW'(NTAPS-1);
  assign w_accept = r_state == IDLE && in_valid;
  assign w_idx = r_wr - r_k - KW'(1);
  assign w_x = (r_state == MAC_L) ? r_lbuf[w_idx] : (r_state == MAC_R) ? r_rbuf[w_idx] : '0;
  assign busy = r_state != IDLE;
  fir_mac #(.AW(AW)) u_mac (
    .clk   (clk),
    .reset (reset),
    .i_clr (w_accept || (r_state == MAC_L && w_last)),
    .i_en  (r_state == MAC_L || r_state == MAC_R),
    .i_x   (w_x),
    .i_c   (coef_at(r_sel, int'(r_k))),
    .o_rnd (w_rnd)
  );
  // state register
  always_ff @(posedge clk) begin
    r_state <= reset ? IDLE : w_next;
  end
  // next state: left pass, right pass, one output cycle
  always_comb begin
    w_next = r_state;
    w_next = (r_state == IDLE) ? (in_valid ? MAC_L : IDLE) :
             (r_state == MAC_L) ? (w_last ? MAC_R : MAC_L) :
             (r_state == MAC_R) ? (w_last ? OUT : MAC_R) : IDLE;
  end
  // delay lines, tap counter, result registers and status flags
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NTAPS; i++) begin
        r_lbuf[i] <= '0;
        r_rbuf[i] <= '0;
      end
      r_wr <= '0;
      r_k <= '0;
      r_sel <= '0;
      r_hold_l <= '0;
      left_out <= '0;
      right_out <= '0;
      out_valid <= 1'b0;
      overrun <= 1'b0;
    end else begin
      out_valid <= r_state == OUT;
      if (in_valid && r_state != IDLE) overrun <= 1'b1;
      if (w_accept) begin
        r_lbuf[r_wr] <= left_in;
        r_rbuf[r_wr] <= right_in;
        r_wr <= r_wr + 1'b1;
        r_sel <= coef_sel;
      end
      r_k <= (r_state == MAC_L || r_state == MAC_R) ? r_k + 1'b1 : '0;
      if (r_state == MAC_L && w_last) r_hold_l <= w_rnd;
      if (r_state == OUT) begin
        left_out <= r_hold_l;
        right_out <= w_rnd;
      end
    end
  end
endmodule

// File: tb/tb_fir_stereo.sv
// tb_fir_stereo: directed stimulus with a sample-history reference model checked every cycle
module tb_fir_stereo;
  logic clk = 0, reset = 1, in_valid = 0;
  logic [23:0] left_in = 0, right_in = 0;
  logic [1:0] coef_sel = 0;
  logic [23:0] left_out, right_out;
  logic out_valid, busy, overrun;
  int total = 0, bad = 0;

  fir_stereo dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .left_in(left_in), .right_in(right_in),
    .coef_sel(coef_sel), .left_out(left_out), .right_out(right_out),
    .out_valid(out_valid), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // reference model: accepted-sample history, newest at index 0
  longint hl[8], hr[8];
  int e = 0, e0 = -1000;
  logic [23:0] pl = 0, pr = 0, el = 0, er = 0;
  logic eov = 0, ebusy = 0, eovr = 0;

  function automatic longint cf(int s, int k);
    case (s)
      0: return (k == 0) ? 65536 : 0;
      1: return 8192;
      2: return (k == 0 || k == 7) ? 4096 : (k == 1 || k == 6) ? 8192 : (k == 2 || k == 5) ? 12288 : 16384;
      default: return (k == 0) ? 32768 : (k == 1) ? -32768 : 0;
    endcase
  endfunction

  function automatic logic [23:0] rs(longint a);
    longint v;
    v = (a + 32768) >>> 16;
    if (v > 8388607) v = 8388607;
    if (v < -8388608) v = -8388608;
    return 24'(v);
  endfunction

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] x);
    total++;
    if (a !== x) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (edge %0d)", nm, a, x, e);
    end
  endtask

  always @(posedge clk) begin
    longint al, ar;
    e++;
    if (reset) begin
      for (int k = 0; k < 8; k++) begin hl[k] = 0; hr[k] = 0; end
      e0 = -1000; el = 0; er = 0; eovr = 0;
    end else if (in_valid) begin
      if (e > e0 + 17) begin
        for (int k = 7; k > 0; k--) begin hl[k] = hl[k-1]; hr[k] = hr[k-1]; end
        hl[0] = longint'($signed(left_in));
        hr[0] = longint'($signed(right_in));
        al = 0; ar = 0;
        for (int k = 0; k < 8; k++) begin
          al += hl[k] * cf(coef_sel, k);
          ar += hr[k] * cf(coef_sel, k);
        end
        pl = rs(al); pr = rs(ar); e0 = e;
      end else eovr = 1;
    end
    eov = !reset && e == e0 + 17;
    if (eov) begin el = pl; er = pr; end
    ebusy = !reset && e >= e0 && e <= e0 + 16;
  end

  always @(negedge clk) begin
    chk("out_valid", out_valid, eov);
    chk("busy", busy, ebusy);
    chk("overrun", overrun, eovr);
    chk("left_out", left_out, el);
    chk("right_out", right_out, er);
  end

  task automatic pulse(input logic [23:0] l, input logic [23:0] r, input logic [1:0] s);
    left_in = l; right_in = r; coef_sel = s; in_valid = 1;
    @(negedge clk);
    in_valid = 0;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (n < 40 && !out_valid) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) chk("out_timeout", 0, 1);
  endtask

  task automatic do_reset();
    reset = 1;
    repeat (2) @(negedge clk);
    reset = 0;
  endtask

  initial begin
    int n, nv;
    repeat (3) @(negedge clk);
    reset = 0;
    chk("rst_left", left_out, 0);
    chk("rst_right", right_out, 0);
    chk("rst_flags", {out_valid, busy, overrun}, 0);
    nv = 0;
    repeat (1000) begin @(negedge clk); nv += out_valid; end
    chk("idle_quiet", nv, 0);

    pulse(24'h000100, 24'hFFFF00, 0);
    coef_sel = 2;
    wait_out(n);
    chk("latency", n + 1, 18);
    chk("id_left", left_out, 24'h000100);
    chk("id_right", right_out, 24'hFFFF00);

    do_reset();
    for (int i = 1; i <= 10; i++) begin
      pulse(24'h001000, 24'hFFF000, 1);
      coef_sel = 2;
      wait_out(n);
      chk("avg_left", left_out, 24'(((i < 8) ? i : 8) * 'h200));
      repeat (230) @(negedge clk);
    end

    do_reset();
    pulse(24'h800000, 24'h7FFFFF, 3);
    wait_out(n);
    chk("diff1_left", left_out, 24'hC00000);
    chk("diff1_right", right_out, 24'h400000);
    repeat (20) @(negedge clk);
    pulse(24'h7FFFFF, 24'h800000, 3);
    wait_out(n);
    chk("diff_sat_hi", left_out, 24'h7FFFFF);
    chk("diff_neg", right_out, 24'h800001);

    do_reset();
    pulse(24'h002000, 24'h003000, 1);
    repeat (4) @(negedge clk);
    pulse(24'h7FFFFF, 24'h7FFFFF, 2);
    coef_sel = 0;
    chk("ovr_set", overrun, 1);
    repeat (11) @(negedge clk);
    pulse(24'h7FFFFF, 24'h7FFFFF, 0);
    nv = out_valid;
    repeat (40) begin @(negedge clk); nv += out_valid; end
    chk("one_out", nv, 1);
    chk("ovr_sticky", overrun, 1);
    pulse(24'h002000, 24'h003000, 1);
    wait_out(n);
    chk("hist_left", left_out, 24'h000800);
    chk("hist_right", right_out, 24'h000C00);

    do_reset();
    pulse(24'h000400, 24'h000400, 1);
    repeat (5) @(negedge clk);
    reset = 1;
    @(negedge clk);
    reset = 0;
    nv = 0;
    repeat (40) begin @(negedge clk); nv += out_valid; end
    chk("abort_quiet", nv, 0);
    chk("abort_zero", {left_out, right_out}, 0);
    pulse(24'h000800, 24'h000800, 1);
    wait_out(n);
    chk("cleared_left", left_out, 24'h000100);

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    bad++;
    $display("FAIL watchdog: got timeout want finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
